// File: rtl/seg_pkg.sv
// Shared 7-segment encodings and BCD decode for the multiplexed display path.
// All patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h7F;

    // Level of a single anode enable when the digit is dark.
    localparam logic AN_OFF = 1'b1;

    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with per-frame snapshot, guard
// interval, leading-zero blanking, per-digit blink and decimal points.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 8,
    parameter int BLINK_FRAMES = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] digits_snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic [NUM_DIGITS-1:0]   blink_snap;
    logic                    blink_phase;
    logic [FC_W-1:0]         frame_cnt;

    logic                    frame_edge;
    logic                    in_guard;
    logic [3:0]              cur_digit;
    seg_t                    cur_seg;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    all_zero;
    logic                    cur_dark;

    assign frame_edge = (idx == '0) && (div_cnt == '0);
    assign in_guard   = (div_cnt < DIV_W'(GUARD));
    assign cur_digit  = digits_snap[{idx, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Scan position: div_cnt within a slot, idx selects the digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // The blink phase is folded into the snapshot (pre-update value) so a
    // whole frame sees one consistent phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_snap <= '0;
            dp_snap     <= '0;
            blink_snap  <= '0;
            blink_phase <= 1'b0;
            frame_cnt   <= '0;
        end else if (frame_edge) begin
            digits_snap <= digits_in;
            dp_snap     <= dp_mask;
            blink_snap  <= blink_mask & {NUM_DIGITS{blink_phase}};
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            all_zero = all_zero & (digits_snap[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            lz_mask[NUM_DIGITS-1-k] = blank_lz && (k != NUM_DIGITS - 1) && all_zero;
        end
    end

    assign cur_dark = in_guard | lz_mask[idx] | blink_snap[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= {NUM_DIGITS{AN_OFF}};
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_edge;
            if (cur_dark) begin
                an  <= {NUM_DIGITS{AN_OFF}};
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= cur_seg;
                dp  <= ~dp_snap[idx];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver against a frame/slot-level display model.
module tb_seg_scan_driver;

    localparam int N     = 6;
    localparam int S     = 4;
    localparam int G     = 1;
    localparam int BF    = 2;
    localparam int FRAME = N * S;
    localparam int OW    = N + 9;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   dp_mask = '0;
    logic [N-1:0]   blink_mask = '0;
    logic           blank_lz = 1'b0;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic           frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (S),
        .GUARD        (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .blank_lz    (blank_lz),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    // Reference model state: edge count since reset and the inputs latched at frame starts.
    int             edge_no = 0;
    int             m_e = 0;
    logic           m_rst = 1'b1;
    logic           m_lz = 1'b0;
    logic [4*N-1:0] m_dig = '0;
    logic [N-1:0]   m_dp = '0;
    logic [N-1:0]   m_blink = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rst   <= 1'b1;
            edge_no <= 0;
        end else begin
            m_rst   <= 1'b0;
            m_e     <= edge_no;
            m_lz    <= blank_lz;
            edge_no <= edge_no + 1;
            if (edge_no % FRAME == 0) begin
                m_dig   <= digits_in;
                m_dp    <= dp_mask;
                m_blink <= blink_mask;
            end
        end
    end

    function automatic logic [OW-1:0] model_out();
        int pos, slot, sub, frame;
        logic dark, fs;
        logic [N-1:0] ean;
        logic [6:0] eseg;
        logic edp;
        if (m_rst) return {{N{1'b1}}, 7'h7F, 1'b1, 1'b0};
        pos   = m_e % FRAME;
        slot  = pos / S;
        sub   = pos % S;
        frame = m_e / FRAME;
        fs    = (pos == 0);
        dark  = (sub < G)
              || (m_lz && slot > 0 && (m_dig >> (4 * slot)) == 0)
              || (m_blink[slot] && ((frame / BF) % 2 == 1));
        if (dark) begin
            ean = {N{1'b1}}; eseg = 7'h7F; edp = 1'b1;
        end else begin
            ean = ~(N'(1) << slot); eseg = SEG_TAB[m_dig[4*slot +: 4]]; edp = ~m_dp[slot];
        end
        return {ean, eseg, edp, fs};
    endfunction

    function automatic logic [4*N-1:0] rand_digits();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++)
            v[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
        return v;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        digits_in = 24'h123459; dp_mask = '0; blink_mask = '0; blank_lz = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({an, seg, dp, frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got an=%h seg=%h dp=%b fs=%b exp an=3f seg=7f dp=1 fs=0",
                         i, an, seg, dp, frame_start);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({an, seg, frame_start} !== {6'h3F, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_first_frame got an=%h seg=%h fs=%b exp an=3f seg=7f fs=1", an, seg, frame_start);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({an, seg, dp, frame_start} !== {6'b111110, 7'h10, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_first_lit got an=%h seg=%h dp=%b fs=%b exp an=3e seg=10 dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
    endtask

    task automatic test_scan_order();
        logic [OW-1:0] exp;
        digits_in = 24'h123459; dp_mask = '0; blink_mask = '0; blank_lz = 1'b0;
        apply_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            exp = model_out();
            n_checks++;
            if ({an, seg, dp, frame_start} !== exp) begin
                n_fail++;
                $display("FAIL scan_order edge=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp);
            end
        end
    endtask

    task automatic test_tear_free();
        logic [OW-1:0] exp;
        digits_in = 24'h123459; dp_mask = '0; blink_mask = '0; blank_lz = 1'b0;
        apply_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            exp = model_out();
            n_checks++;
            if ({an, seg, dp, frame_start} !== exp) begin
                n_fail++;
                $display("FAIL tear_free edge=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp);
            end
            if (i == 13) begin
                n_checks++;
                if (seg !== 7'h30) begin
                    n_fail++;
                    $display("FAIL tear_free_slot3 got seg=%h exp seg=30", seg);
                end
            end
            if (i == FRAME + 1) begin
                n_checks++;
                if (seg !== 7'h10) begin
                    n_fail++;
                    $display("FAIL tear_free_new_frame got seg=%h exp seg=10", seg);
                end
            end
            if (i == 9) digits_in = 24'h999999;
        end
    endtask

    task automatic test_leading_zero();
        logic [OW-1:0] exp;
        digits_in = 24'h000705; dp_mask = '0; blink_mask = '0; blank_lz = 1'b1;
        apply_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            exp = model_out();
            n_checks++;
            if ({an, seg, dp, frame_start} !== exp) begin
                n_fail++;
                $display("FAIL leading_zero edge=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp);
            end
            if (i == 3 * S + 2 || i == FRAME + S + 2) begin
                n_checks++;
                if (an !== 6'h3F) begin
                    n_fail++;
                    $display("FAIL leading_zero_dark edge=%0d got an=%h exp an=3f", i, an);
                end
            end
            if (i == FRAME - 1) digits_in = '0;
        end
    endtask

    task automatic test_invalid_dp();
        logic [OW-1:0] exp;
        digits_in = 24'h12345C; dp_mask = 6'b000001; blink_mask = '0; blank_lz = 1'b0;
        apply_reset();
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            exp = model_out();
            n_checks++;
            if ({an, seg, dp, frame_start} !== exp) begin
                n_fail++;
                $display("FAIL invalid_dp edge=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp);
            end
            if (i == 1) begin
                n_checks++;
                if ({seg, dp} !== {7'h3F, 1'b0}) begin
                    n_fail++;
                    $display("FAIL invalid_dp_digit0 got seg=%h dp=%b exp seg=3f dp=0", seg, dp);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [OW-1:0] exp;
        digits_in = 24'h123459; dp_mask = '0; blink_mask = 6'b000011; blank_lz = 1'b0;
        apply_reset();
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(posedge clk); #1;
            exp = model_out();
            n_checks++;
            if ({an, seg, dp, frame_start} !== exp) begin
                n_fail++;
                $display("FAIL blink edge=%0d got %h exp %h", i, {an, seg, dp, frame_start}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] exp;
        apply_reset();
        for (int it = 0; it < 24; it++) begin
            digits_in  = rand_digits();
            dp_mask    = N'($urandom);
            blink_mask = N'($urandom);
            blank_lz   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rst = 1'b1;
            for (int c = 0; c < int'($urandom_range(8, 60)); c++) begin
                @(posedge clk); #1;
                rst = 1'b0;
                exp = model_out();
                n_checks++;
                if ({an, seg, dp, frame_start} !== exp) begin
                    n_fail++;
                    $display("FAIL random it=%0d c=%0d got %h exp %h", it, c, {an, seg, dp, frame_start}, exp);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_leading_zero();
        test_invalid_dp();
        test_blink();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream consumer of the cascaded BCD time counters (mod-10 / mod-6 chain, HH:MM:SS).
- Takes all digit values in parallel and drives a multiplexed common-anode 7-segment display, one digit per scan slot.
- Snapshots the digits once per frame so no torn values are shown.
- Adds a ghost-suppression guard interval, leading-zero blanking, per-digit blinking and decimal points.

Parameters:
- NUM_DIGITS, 6: digits scanned; digit 0 is least significant.
- SCAN_DIV, 50000: clk cycles per digit slot; must be >= 2.
- GUARD, 8: cycles at the start of each slot with all anodes off; 1 <= GUARD < SCAN_DIV.
- BLINK_FRAMES, 100: full frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  BCD digits; digit i is bits [4i+3:4i].
- dp_mask  in  NUM_DIGITS  1 = light the decimal point of digit i.
- blink_mask  in  NUM_DIGITS  1 = digit i blinks.
- blank_lz  in  1  1 = enable leading-zero blanking.
- an  out  NUM_DIGITS  digit enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when a snapshot is taken.

Behaviour:
- Reset (rst=1 at posedge):
  - div_cnt=0, idx=0, snapshot regs=0, blink_phase=0, frame_cnt=0.
  - an=all 1, seg=7'h7F, dp=1, frame_start=0.
  - rst overrides everything. Reset mid-frame aborts the frame; the next frame starts from idx 0 with a fresh snapshot.
- Scan counters:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx increments; NUM_DIGITS-1 wraps to 0.
- Snapshot:
  - When the state is (idx==0, div_cnt==0), load digits_in, dp_mask and blink_mask into the snapshot regs and pulse frame_start (registered, visible the same cycle the snapshot is).
  - This includes the first cycle after reset release.
  - Input changes during a frame are ignored until the next snapshot.
- Blink:
  - frame_cnt increments at each snapshot.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - Effective blank for digit i: blink_phase=1 and snapshot blink_mask[i]=1.
- Leading-zero blanking:
  - With blank_lz=1, digit i (i>0) is blanked if it and every more significant snapshot digit equal 0.
  - Digit 0 is never LZ-blanked.
- Decode (snapshot digit):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Values 10..15 give a dash, 3F.
- Output stage (registered, one-cycle latency from counter state):
  - If div_cnt < GUARD, or the current digit is LZ- or blink-blanked: an=all 1, seg=7F, dp=1.
  - Otherwise: an = one-hot low at idx, seg = decode, dp = ~dp_mask_snap[idx].
- Because GUARD >= 1, output never uses a stale snapshot across a frame boundary.
- Frame period = NUM_DIGITS*SCAN_DIV cycles; no input handshake.

Decomposition:
- Package seg_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH=7'h3F, SEG_BLANK=7'h7F;
  - AN_OFF;
  - a function bcd_to_seg(4-bit) returning 7-bit active-low.
- One natural sub-module: bcd_to_7seg (combinational decoder wrapping bcd_to_seg).
- Counters, snapshot, blanking logic and output registers stay in seg_scan_driver.

Test Plan:
(Parameters NUM_DIGITS=6, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2 unless stated.)
- Reset: hold rst 3 cycles with digits_in=24'h123459 -> an=6'h3F, seg=7'h7F, dp=1 throughout. After release, frame_start pulses, and the first lit cycle shows an=6'b111110, seg=7'h10 (digit 9).
- Scan order: digits_in=24'h123459, blank_lz=0 -> each 4-cycle slot has 1 dark cycle then 3 lit cycles. Slot sequence is 9,5,4,3,2,1 with seg 10,12,19,30,24,79. The an low bit walks 0->5, then repeats.
- Tear-free: change digits_in to 24'h999999 during slot 2 -> the remaining slots still show 4,3,2,1; 9s appear only after the next frame_start.
- Leading zeros: digits_in=24'h000705, blank_lz=1 -> digits 5,4,3 keep an high. Digit 2 shows 78, digit 1 shows 40, digit 0 shows 12. With digits_in=0, only digit 0 lights (40).
- Invalid/dp: digit 0 = 4'hC, dp_mask=6'b000001 -> digit 0 shows seg=3F, dp=0. Other digits have dp=1.
- Blink: blink_mask=6'b000011 -> digits 0,1 lit in frames 0,1, dark in frames 2,3, lit in frames 4,5. Digits 2..5 are unaffected.
